// File: rtl/logic_reduce.sv
// logic_reduce: folds the beats of a frame bitwise (AND / OR / XOR / NAND)
// and presents the folded vector plus a one-bit reduction until consumed.
//
// Optional feature macro: LOGIC_REDUCE_CNT_EN adds a saturating beat counter
// exposed on out_beats / out_sat.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   beat handshake
//   in_data [WIDTH]       operand beat
//   in_last               final beat of the frame
//   mode [2]              00 AND, 01 OR, 10 XOR, 11 NAND (taken on first beat)
//   out_valid / out_ready result handshake
//   out_vec [WIDTH]       folded vector (inverted for NAND)
//   out_bit               reduction of the folded vector
//   out_beats [CNT_WIDTH] beats in frame (LOGIC_REDUCE_CNT_EN only)
//   out_sat               count saturated (LOGIC_REDUCE_CNT_EN only)
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACC   | folding further beats into acc
// HOLD  | result held until out_ready
module logic_reduce #(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_vec,
    output logic                 out_bit
`ifdef LOGIC_REDUCE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] out_beats,
    output logic                 out_sat
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [1:0]        mode_q, mode_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              accept;

`ifdef LOGIC_REDUCE_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sat_q, sat_d;
`endif

    // in_ready is a flop so it stays low through reset and rises on the
    // first edge after release.
    assign accept = in_valid & ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    mode_d  = mode;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    case (mode_q)
                        2'b01:   acc_d = acc_q | in_data;
                        2'b10:   acc_d = acc_q ^ in_data;
                        default: acc_d = acc_q & in_data;  // AND and NAND
                    endcase
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

`ifdef LOGIC_REDUCE_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (accept && state_q == IDLE) begin
            cnt_d = CNT_ONE;
            sat_d = 1'b0;
        end else if (accept) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mode_q  <= 2'b00;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef LOGIC_REDUCE_CNT_EN
            cnt_q   <= '0;
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
`ifdef LOGIC_REDUCE_CNT_EN
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
`endif
        end
    end

    always_comb begin
        case (mode_q)
            2'b00: begin out_vec = acc_q;  out_bit = &acc_q;  end
            2'b01: begin out_vec = acc_q;  out_bit = |acc_q;  end
            2'b10: begin out_vec = acc_q;  out_bit = ^acc_q;  end
            default: begin out_vec = ~acc_q; out_bit = ~&acc_q; end
        endcase
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
`ifdef LOGIC_REDUCE_CNT_EN
    assign out_beats = cnt_q;
    assign out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_logic_reduce.sv
module tb_logic_reduce;

    localparam int W    = 3;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_vec;
    logic          out_bit;
`ifdef LOGIC_REDUCE_CNT_EN
    logic [CW-1:0] out_beats;
    logic          out_sat;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] beats [0:15];
    logic [1:0]   modes [0:15];

    always #5 clk = ~clk;

    logic_reduce #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_bit   (out_bit)
`ifdef LOGIC_REDUCE_CNT_EN
        ,
        .out_beats (out_beats),
        .out_sat   (out_sat)
`endif
    );

    // Reference: fold n beats using the mode given with the first beat.
    function automatic logic [W:0] ref_fold(input int n);
        int a, ones;
        logic [1:0] md;
        int full;
        logic [W-1:0] v;
        logic b;
        full = (1 << W) - 1;
        md = modes[0];
        a = int'(beats[0]);
        for (int i = 1; i < n; i++) begin
            if (md == 2'b01)      a = a | int'(beats[i]);
            else if (md == 2'b10) a = a ^ int'(beats[i]);
            else                  a = a & int'(beats[i]);
        end
        ones = 0;
        for (int i = 0; i < W; i++) ones += (a >> i) & 1;
        case (md)
            2'b00: begin v = W'(a);        b = (a == full); end
            2'b01: begin v = W'(a);        b = (a != 0);    end
            2'b10: begin v = W'(a);        b = (ones % 2) == 1; end
            default: begin v = W'(full - a); b = (a != full); end
        endcase
        return {b, v};
    endfunction

    // Drives n beats from beats[]/modes[], optionally with idle gaps that
    // carry a stray in_last, then waits (bounded) for out_valid.
    task automatic run_frame(input int n, input bit gaps, output bit got, output int lat);
        int k;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = W'($urandom);
                mode     = 2'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == n - 1);
            mode     = modes[i];
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (out_vec !== 3'b000 || out_bit !== 1'b0) begin bad++; $display("FAIL reset_out got=%b/%b exp=000/0", out_vec, out_bit); end
`ifdef LOGIC_REDUCE_CNT_EN
        total++; if (out_beats !== '0 || out_sat !== 1'b0) begin bad++; $display("FAIL reset_count got=%0d/%b exp=0/0", out_beats, out_sat); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        bit got; int lat;
        beats[0] = 3'b111; modes[0] = 2'b00;
        run_frame(1, 1'b0, got, lat);
        total++; if (lat !== 1 || !got) begin bad++; $display("FAIL single_latency got=%0d exp=1", lat); end
        total++; if (out_vec !== 3'b111 || out_bit !== 1'b1) begin bad++; $display("FAIL single_111 got=%b/%b exp=111/1", out_vec, out_bit); end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
        beats[0] = 3'b110;
        run_frame(1, 1'b0, got, lat);
        total++; if (out_vec !== 3'b110 || out_bit !== 1'b0) begin bad++; $display("FAIL single_110 got=%b/%b exp=110/0", out_vec, out_bit); end
        consume();
    endtask

    task automatic test_and_nand();
        bit got; int lat;
        beats[0] = 3'b111; beats[1] = 3'b101; beats[2] = 3'b111;
        for (int i = 0; i < 3; i++) modes[i] = 2'b00;
        run_frame(3, 1'b0, got, lat);
        total++; if (!got || lat !== 1 || out_vec !== 3'b101 || out_bit !== 1'b0) begin bad++; $display("FAIL and_frame got=%b/%b lat=%0d exp=101/0 lat=1", out_vec, out_bit, lat); end
        consume();
        for (int i = 0; i < 3; i++) modes[i] = 2'b11;
        run_frame(3, 1'b0, got, lat);
        total++; if (!got || out_vec !== 3'b010 || out_bit !== 1'b1) begin bad++; $display("FAIL nand_frame got=%b/%b exp=010/1", out_vec, out_bit); end
        consume();
    endtask

    task automatic test_xor_mode();
        bit got; int lat;
        beats[0] = 3'b001; beats[1] = 3'b011; beats[2] = 3'b100;
        for (int i = 0; i < 3; i++) modes[i] = 2'b10;
        run_frame(3, 1'b0, got, lat);
        total++; if (!got || out_vec !== 3'b110 || out_bit !== 1'b0) begin bad++; $display("FAIL xor_frame got=%b/%b exp=110/0", out_vec, out_bit); end
        consume();
        modes[1] = 2'b01;
        run_frame(3, 1'b0, got, lat);
        total++; if (!got || out_vec !== 3'b110 || out_bit !== 1'b0) begin bad++; $display("FAIL xor_mode_change got=%b/%b exp=110/0", out_vec, out_bit); end
        consume();
    endtask

    task automatic test_hold_stall();
        bit got; int lat;
        beats[0] = 3'b010; beats[1] = 3'b100; modes[0] = 2'b01; modes[1] = 2'b01;
        run_frame(2, 1'b0, got, lat);
        in_valid = 1'b1; in_data = 3'b111; in_last = 1'b1; mode = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== 3'b110 || out_bit !== 1'b1) begin
                bad++; $display("FAIL hold_stable c=%0d got v=%b r=%b vec=%b bit=%b exp v=1 r=0 vec=110 bit=1", c, out_valid, in_ready, out_vec, out_bit);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_beat_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midframe();
        bit got; int lat;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 3'b101; in_last = 1'b0; mode = 2'b10;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_rst got v=%b r=%b exp 0/0", out_valid, in_ready); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_result got=%b exp=0", out_valid); end
        beats[0] = 3'b011; modes[0] = 2'b01;
        run_frame(1, 1'b0, got, lat);
        total++; if (!got || lat !== 1 || out_vec !== 3'b011 || out_bit !== 1'b1) begin bad++; $display("FAIL midreset_fresh got=%b/%b lat=%0d exp=011/1 lat=1", out_vec, out_bit, lat); end
        consume();
    endtask

    task automatic test_random();
        bit got; int lat, n, stall;
        logic [W:0] exp;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                beats[i] = W'($urandom);
                modes[i] = (i == 0) ? 2'($urandom) : ($urandom_range(0, 3) == 0 ? 2'($urandom) : modes[0]);
            end
            exp = ref_fold(n);
            run_frame(n, 1'b1, got, lat);
            total++; if (!got || lat !== 1) begin bad++; $display("FAIL rand_latency f=%0d got=%0d exp=1", f, lat); end
            total++; if (out_vec !== exp[W-1:0] || out_bit !== exp[W]) begin
                bad++; $display("FAIL rand_result f=%0d n=%0d got=%b/%b exp=%b/%b", f, n, out_vec, out_bit, exp[W-1:0], exp[W]);
            end
`ifdef LOGIC_REDUCE_CNT_EN
            total++; if (int'(out_beats) !== ((n > CMAX) ? CMAX : n) || out_sat !== (n > CMAX)) begin
                bad++; $display("FAIL rand_count f=%0d n=%0d got=%0d/%b", f, n, out_beats, out_sat);
            end
`endif
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            consume();
        end
    endtask

`ifdef LOGIC_REDUCE_CNT_EN
    task automatic test_count();
        bit got; int lat;
        for (int i = 0; i < 5; i++) begin beats[i] = 3'b111; modes[i] = 2'b00; end
        run_frame(5, 1'b0, got, lat);
        total++; if (!got || out_beats !== 2'd3 || out_sat !== 1'b1) begin bad++; $display("FAIL count_sat got=%0d/%b exp=3/1", out_beats, out_sat); end
        consume();
        run_frame(2, 1'b0, got, lat);
        total++; if (!got || out_beats !== 2'd2 || out_sat !== 1'b0) begin bad++; $display("FAIL count_clear got=%0d/%b exp=2/0", out_beats, out_sat); end
        consume();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_and_nand();
        test_xor_mode();
        test_hold_stall();
        test_reset_midframe();
`ifdef LOGIC_REDUCE_CNT_EN
        test_count();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_reduce.md
LOGIC_REDUCE -- requirements
Module: logic_reduce

Interface
REQ-001 Parameter WIDTH, default 3: lane width of in_data/out_vec, legal range 1..64.
REQ-002 Parameter CNT_WIDTH, default 8: beat-counter width, legal range 1..16.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  beat present on in_data.
REQ-006 Port in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port in_data  input  WIDTH  operand beat.
REQ-008 Port in_last  input  1  final beat of the frame.
REQ-009 Port mode  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 Port out_valid  output  1  result held.
REQ-011 Port out_ready  input  1  consumer takes the result.
REQ-012 Port out_vec  output  WIDTH  bitwise fold of all beats in the frame.
REQ-013 Port out_bit  output  1  reduction of the fold to one bit.
REQ-014 Ports out_beats (output, CNT_WIDTH, beats in frame) and out_sat (output, 1, count saturated) exist only when LOGIC_REDUCE_CNT_EN is defined.

Function
REQ-015 FSM states: IDLE, ACC, HOLD; a beat is accepted when in_valid && in_ready.
REQ-016 in_ready = 1 in IDLE and ACC, 0 in HOLD; out_valid = 1 in HOLD only.
REQ-017 IDLE accept: acc <= in_data, mode_q <= mode; next state HOLD if in_last, else ACC.
REQ-018 ACC accept: acc <= acc op(mode_q) in_data (AND/OR/XOR per bit; NAND folds as AND); next state HOLD if in_last, else ACC.
REQ-019 mode is sampled only on the first beat; changes mid-frame are ignored.
REQ-020 No accept: acc and state hold; in_last with in_valid low has no effect.
REQ-021 out_vec = acc for AND/OR/XOR, ~acc for NAND; out_bit = &acc, |acc, ^acc, ~&acc respectively.
REQ-022 Latency: out_valid rises the cycle after the last beat is accepted; a single-beat frame gives a one-cycle result.
REQ-023 HOLD: out_vec, out_bit and the count ports stay stable until out_ready = 1, then the block returns to IDLE the next cycle.
REQ-024 The first beat of the next frame is never accepted in the out_ready handshake cycle, because in_ready is 0 in HOLD.
REQ-025 Outputs are registered or decoded from registered state only; there is no combinational path from in_* to out_*.

Reset
REQ-026 rst_n low immediately forces IDLE, acc = 0, mode_q = 00, out_valid = 0, and out_beats = 0 / out_sat = 0 where present.
REQ-027 While rst_n is low, in_ready = 0; in_ready = 1 from the first edge after release.
REQ-028 Reset mid-frame or in HOLD discards the partial frame and the held result; no out_valid is produced for it.

Configuration
REQ-029 Macro LOGIC_REDUCE_CNT_EN defined: a counter resets to 1 on each first beat and increments per accepted beat, saturating at 2^CNT_WIDTH-1.
REQ-030 With LOGIC_REDUCE_CNT_EN defined, out_sat = 1 once a frame has attempted to exceed saturation, and both count ports are cleared on the next first beat.
REQ-031 Macro LOGIC_REDUCE_CNT_EN undefined: the counter and both count ports are absent, and all other behaviour is identical.

Verification
REQ-032 WIDTH=3, AND, single beat 111 with last -> out_vec 111, out_bit 1 the next cycle; repeat with 110 -> out_bit 0.
REQ-033 AND, beats 111, 101, 111 (last on the third) -> out_vec 101, out_bit 0; NAND with the same beats -> out_vec 010, out_bit 1.
REQ-034 XOR, beats 001, 011, 100 -> out_vec 110, out_bit 0; mode changed to OR on beat 2 is ignored (same result).
REQ-035 Hold out_ready = 0 for 5 cycles after out_valid -> outputs stable, in_ready = 0, and an offered in_valid beat is not consumed.
REQ-036 Assert rst_n = 0 after 2 of 3 beats -> out_valid stays 0; a fresh frame after release yields only its own result.
REQ-037 LOGIC_REDUCE_CNT_EN defined, CNT_WIDTH=2, 5-beat frame -> out_beats 3, out_sat 1; the next 2-beat frame -> out_beats 2, out_sat 0.
